// File: rtl/trigger_surround_cache_p.sv
// Trigger surround cache: keeps a circular window of ADC samples around a
// trigger event (PRE before, the trigger sample, DEPTH-PRE-1 after), stamps
// the trigger time and shifts the window out serially, oldest sample first.
module trigger_surround_cache_p #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 32,
    parameter int PRE     = 8,
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               sbf,
    input  logic               trig_mode,
    input  logic [DATA_W-1:0]  trig_level,
    input  logic [DATA_W-1:0]  adc_data,
    input  logic               adc_rdy,
    output logic               adc_req,
    output logic               trd,
    output logic [TIMER_W-1:0] trigtm,
    output logic               sd,
    output logic               sd_valid,
    output logic               cd,
    output logic               busy
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int POST_LEN = DEPTH - PRE - 1;

    localparam logic [PTR_W-1:0] PRE_LAST  = PTR_W'(PRE - 1);
    localparam logic [PTR_W-1:0] PRE_OFS   = PTR_W'(PRE);
    localparam logic [PTR_W-1:0] POST_INIT = PTR_W'(POST_LEN);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] WORD_LAST = PTR_W'(DEPTH - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_ARMED,
        S_POST,
        S_DONE,
        S_SEND
    } state_t;

    state_t state, next_state;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [TIMER_W-1:0] timer;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   trig_idx;
    logic [PTR_W-1:0]   fill_cnt;
    logic [PTR_W-1:0]   post_cnt;
    logic [PTR_W-1:0]   word_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  shift_reg;
    logic               prev_below;

    logic               level_ok;
    logic               accept;
    logic               hit;
    logic               arm;
    logic               send_go;
    logic               send_last;
    logic [PTR_W-1:0]   send_first;
    logic [PTR_W-1:0]   rd_next;

    assign level_ok   = (adc_data >= trig_level);
    assign send_first = trig_idx - PRE_OFS;
    assign rd_next    = rd_ptr + PTR_ONE;

    // All outputs are decodes of, or bits of, registered state.
    assign adc_req = (state == S_PREFILL) || (state == S_ARMED) || (state == S_POST);
    assign busy    = (state != S_IDLE);
    assign sd      = shift_reg[DATA_W-1];

    // Next-state and per-cycle control strobes.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        next_state = state;
        accept     = 1'b0;
        hit        = 1'b0;
        arm        = 1'b0;
        send_go    = 1'b0;
        send_last  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    arm        = 1'b1;
                    next_state = S_PREFILL;
                end
            end
            S_PREFILL: begin
                accept = adc_rdy;
                if (adc_rdy && fill_cnt == PRE_LAST) next_state = S_ARMED;
            end
            S_ARMED: begin
                accept = adc_rdy;
                if (adc_rdy && level_ok && (!trig_mode || prev_below)) begin
                    hit        = 1'b1;
                    next_state = (POST_LEN == 0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                accept = adc_rdy;
                if (adc_rdy && post_cnt == PTR_ONE) next_state = S_DONE;
            end
            S_DONE: begin
                if (sbf) begin
                    send_go    = 1'b1;
                    next_state = S_SEND;
                end else if (start) begin
                    arm        = 1'b1;
                    next_state = S_PREFILL;
                end
            end
            S_SEND: begin
                if (bit_cnt == BIT_LAST && word_cnt == WORD_LAST) begin
                    send_last  = 1'b1;
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Sample store; contents are meaningless until refilled after a re-arm.
    always_ff @(posedge clk) begin
        // NOTE: the buffer is deliberately not reset, so it maps onto plain RAM.
        if (accept) mem[wr_ptr] <= adc_data;
    end

    // Capture bookkeeping, trigger stamp and serial shifter.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            trig_idx   <= '0;
            fill_cnt   <= '0;
            post_cnt   <= '0;
            word_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            prev_below <= 1'b0;
            trd        <= 1'b0;
            trigtm     <= '0;
            sd_valid   <= 1'b0;
            cd         <= 1'b0;
        end else begin
            cd <= send_last;

            if (arm) begin
                timer      <= '0;
                wr_ptr     <= '0;
                fill_cnt   <= '0;
                trd        <= 1'b0;
                prev_below <= 1'b1;
            end else if (state != S_IDLE) begin
                timer <= timer + TIMER_W'(1);
            end

            if (accept) begin
                wr_ptr     <= wr_ptr + PTR_ONE;
                prev_below <= !level_ok;
            end

            if (state == S_PREFILL && accept) fill_cnt <= fill_cnt + PTR_ONE;

            if (hit) begin
                trig_idx <= wr_ptr;
                trigtm   <= timer;
                trd      <= 1'b1;
                post_cnt <= POST_INIT;
            end

            if (state == S_POST && accept) post_cnt <= post_cnt - PTR_ONE;

            if (send_go) begin
                rd_ptr    <= send_first;
                word_cnt  <= '0;
                bit_cnt   <= '0;
                shift_reg <= mem[send_first];
                sd_valid  <= 1'b1;
            end

            if (state == S_SEND) begin
                if (send_last) begin
                    sd_valid  <= 1'b0;
                    shift_reg <= '0;
                    trd       <= 1'b0;
                end else if (bit_cnt == BIT_LAST) begin
                    bit_cnt   <= '0;
                    word_cnt  <= word_cnt + PTR_ONE;
                    rd_ptr    <= rd_next;
                    shift_reg <= mem[rd_next];
                end else begin
                    bit_cnt   <= bit_cnt + BIT_ONE;
                    shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_trigger_surround_cache_p.sv
// Directed bench for trigger_surround_cache_p with default parameters
// (DATA_W=8, DEPTH=32, PRE=8): captures, trigger stamps and serial readout.
module tb_trigger_surround_cache_p;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sbf;
    logic        trig_mode;
    logic [7:0]  trig_level;
    logic [7:0]  adc_data;
    logic        adc_rdy;
    logic        adc_req;
    logic        trd;
    logic [31:0] trigtm;
    logic        sd;
    logic        sd_valid;
    logic        cd;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    trigger_surround_cache_p dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sbf        (sbf),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .adc_data   (adc_data),
        .adc_rdy    (adc_rdy),
        .adc_req    (adc_req),
        .trd        (trd),
        .trigtm     (trigtm),
        .sd         (sd),
        .sd_valid   (sd_valid),
        .cd         (cd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Guard against a stuck run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample value for pattern p at accepted-sample index s.
    function automatic logic [7:0] pat_data(input int p, input int s);
        case (p)
            0:       return 8'(s);
            1:       return 8'hFF;
            default: return (s == 10) ? 8'h10 : 8'h90;
        endcase
    endfunction

    task automatic check_zero(input string pfx);
        check({pfx, "_adc_req"},  adc_req,  0);
        check({pfx, "_trd"},      trd,      0);
        check({pfx, "_trigtm"},   trigtm,   0);
        check({pfx, "_sd"},       sd,       0);
        check({pfx, "_sd_valid"}, sd_valid, 0);
        check({pfx, "_cd"},       cd,       0);
        check({pfx, "_busy"},     busy,     0);
    endtask

    task automatic pulse_reset(input string pfx);
        reset = 1'b1;
        step();
        check_zero(pfx);
        reset = 1'b0;
    endtask

    // Arm, feed samples every gap cycles, and watch for the trigger.
    task automatic capture(input string pfx, input int gap, input int pat,
                           input logic mode, input logic [7:0] lvl, input bit stop_at_trig,
                           input int exp_s, input int exp_tm);
        int s = 0;
        int c = 0;
        int cds = 0;
        bit seen = 1'b0;
        bit fin = 1'b0;
        bit acc;
        trig_mode  = mode;
        trig_level = lvl;
        start = 1'b1;
        step();
        start = 1'b0;
        check({pfx, "_arm_trd"}, trd, 0);
        check({pfx, "_arm_req"}, adc_req, 1);
        while (!fin && c < 2000) begin
            adc_rdy  = (c % gap == 0);
            adc_data = pat_data(pat, s);
            acc      = adc_req && adc_rdy;
            step();
            if (acc) s++;
            if (cd) cds++;
            if (trd && !seen) begin
                seen = 1'b1;
                check({pfx, "_trig_sample"}, s - 1, exp_s);
                check({pfx, "_trigtm"}, trigtm, exp_tm);
                if (stop_at_trig) fin = 1'b1;
            end
            if (!adc_req) fin = 1'b1;
            c++;
        end
        adc_rdy = 1'b0;
        check({pfx, "_trig_seen"}, seen, 1);
        check({pfx, "_cd_quiet"}, cds, 0);
        if (!stop_at_trig) begin
            check({pfx, "_samples"}, s, exp_s + 24);
            check({pfx, "_done_busy"}, busy, 1);
            check({pfx, "_done_trd"}, trd, 1);
            check({pfx, "_done_tm"}, trigtm, exp_tm);
        end
    endtask

    // Request readout in DONE and compare the serial stream with the window.
    task automatic send(input string pfx, input int pat, input int trig_s, input bit with_start);
        int bits = 0;
        int bad = 0;
        int cds = 0;
        logic [7:0] acc_byte = '0;
        logic [7:0] first_byte = '0;
        sbf   = 1'b1;
        start = with_start;
        step();
        sbf   = 1'b0;
        start = 1'b0;
        check({pfx, "_send_valid"}, sd_valid, 1);
        check({pfx, "_send_trd"}, trd, 1);
        while (sd_valid && bits < 1000) begin
            acc_byte = {acc_byte[6:0], sd};
            bits++;
            if (cd) cds++;
            if (bits % 8 == 0) begin
                if (acc_byte !== pat_data(pat, trig_s - 8 + bits / 8 - 1)) bad++;
                if (bits == 8) first_byte = acc_byte;
            end
            step();
        end
        check({pfx, "_bits"}, bits, 256);
        check({pfx, "_bad_bytes"}, bad, 0);
        check({pfx, "_first_byte"}, first_byte, pat_data(pat, trig_s - 8));
        check({pfx, "_last_byte"}, acc_byte, pat_data(pat, trig_s + 23));
        check({pfx, "_cd_early"}, cds, 0);
        check({pfx, "_cd"}, cd, 1);
        check({pfx, "_end_trd"}, trd, 0);
        check({pfx, "_end_busy"}, busy, 0);
        step();
        check({pfx, "_cd_once"}, cd, 0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        sbf        = 1'b0;
        trig_mode  = 1'b0;
        trig_level = 8'h00;
        adc_data   = 8'h00;
        adc_rdy    = 1'b0;
        step();
        step();
        check_zero("reset");
        reset = 1'b0;
        step();
        check_zero("idle");

        // 1: ramp, level mode, trigger on 0x20 at cycle 32.
        capture("s1", 1, 0, 1'b0, 8'h20, 1'b0, 32, 32);
        send("s1", 0, 32, 1'b0);

        // 2: constant 0xFF, first 8 samples are prefill, trigger on the 9th.
        capture("s2", 1, 1, 1'b0, 8'h80, 1'b0, 8, 8);
        send("s2", 1, 8, 1'b0);

        // 3: edge mode, only the 0x90 after 0x10 qualifies.
        capture("s3", 1, 2, 1'b1, 8'h80, 1'b0, 11, 11);
        send("s3", 2, 11, 1'b0);

        // 4: one sample every 3 cycles; stamp counts cycles.
        capture("s4", 3, 0, 1'b0, 8'h20, 1'b0, 32, 96);
        send("s4", 0, 32, 1'b0);

        // 5: reset mid-POST, reset mid-SEND, then a clean capture.
        capture("s5a", 1, 0, 1'b0, 8'h20, 1'b1, 32, 32);
        check("s5a_in_post", adc_req, 1);
        pulse_reset("s5_post_rst");
        capture("s5b", 1, 0, 1'b0, 8'h20, 1'b0, 32, 32);
        sbf = 1'b1;
        step();
        sbf = 1'b0;
        for (int i = 0; i < 50; i++) step();
        check("s5b_mid_send", sd_valid, 1);
        pulse_reset("s5_send_rst");
        capture("s5c", 1, 0, 1'b0, 8'h20, 1'b0, 32, 32);
        send("s5c", 0, 32, 1'b0);

        // 6: start+sbf together takes SEND; start alone re-arms.
        capture("s6a", 1, 0, 1'b0, 8'h20, 1'b0, 32, 32);
        send("s6a", 0, 32, 1'b1);
        capture("s6b", 1, 0, 1'b0, 8'h20, 1'b0, 32, 32);
        capture("s6c", 1, 2, 1'b1, 8'h80, 1'b0, 11, 11);
        send("s6c", 2, 11, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
